// File: rtl/ccsds_tx_pkg.sv
// Shared types and constants for the CCSDS transmit bit path.
package ccsds_tx_pkg;

  // Width of bit-period configuration and bit timers.
  localparam int unsigned CPB_W = 32;

  // Standard CCSDS Attached Sync Marker, transmitted bit 31 first.
  localparam logic [31:0] ASM_DEFAULT = 32'h1ACF_FC1D;

  // Framer sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ASM   = 2'd1,
    DATA  = 2'd2,
    STALL = 2'd3
  } framer_state_e;

  // Pick one bit of a 32-bit marker word by its index.
  function automatic logic sel_bit(input logic [31:0] word, input logic [4:0] idx);
    return word[idx];
  endfunction

endpackage

// File: rtl/ccsds_bit_timer.sv
// Bit-period timer: counts 0..cp while running, where cp is latched on load.
// Produces a strobe on the first clock of each bit and an advance pulse on
// the last clock. Parks at 0 whenever not running so the next bit restarts
// with a fresh strobe. The compare is an equality test, so cp = all-ones is
// legal and never wraps mid-bit.
module ccsds_bit_timer
  import ccsds_tx_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CPB_W-1:0] period,
  input  logic             load,
  input  logic             run,
  output logic             strobe,
  output logic             advance
);

  logic [CPB_W-1:0] cp_r;
  logic [CPB_W-1:0] timer_r;
  logic             at_end_s;

  assign at_end_s = (timer_r == cp_r);
  assign strobe   = run && (timer_r == {CPB_W{1'b0}});
  assign advance  = run && at_end_s;

  // Capture the bit period at each frame start; held for the whole frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cp_r <= {CPB_W{1'b0}};
    end else if (load) begin
      cp_r <= period;
    end
  end

  // Count through one bit period while running, otherwise sit at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_r <= {CPB_W{1'b0}};
    end else if (load || !run || at_end_s) begin
      timer_r <= {CPB_W{1'b0}};
    end else begin
      timer_r <= timer_r + 32'd1;
    end
  end

endmodule

// File: rtl/ccsds_asm_framer.sv
// CCSDS ASM framer: prepends the sync marker to each transfer frame and
// serializes marker plus frame bytes MSB-first at a programmable bit rate.
// A one-byte holding buffer decouples the byte handshake from the shift
// register; the FSM stalls (and flags underrun) if a byte is late mid-frame.
module ccsds_asm_framer
  import ccsds_tx_pkg::*;
#(
  parameter int unsigned FRAME_BYTES = 223,
  parameter logic [31:0] ASM_WORD    = ASM_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CPB_W-1:0] cycles_per_bit,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             bit_o,
  output logic             bit_valid_o,
  output logic             bit_strobe_o,
  output logic             asm_o,
  output logic             frame_start_o,
  output logic             underrun_o
);

  localparam int unsigned       BCNT_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);

  framer_state_e     state_r, state_n_s;
  logic [4:0]        bit_idx_r, bit_idx_n_s;
  logic [BCNT_W-1:0] byte_cnt_r, byte_cnt_n_s;
  logic [7:0]        buf_r;
  logic [7:0]        shreg_r;
  logic              buf_full_r;
  logic              ready_r;
  logic              underrun_r, underrun_n_s;
  logic              accept_s, drain_s, load_s, run_s;
  logic              strobe_s, advance_s;
  logic              bit_s;

  // ready_r mirrors !buf_full_r but stays low through reset.
  assign accept_s = valid_i && ready_r;
  assign run_s    = (state_r == ASM) || (state_r == DATA);

  ccsds_bit_timer u_timer (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .period  (cycles_per_bit),
    .load    (load_s),
    .run     (run_s),
    .strobe  (strobe_s),
    .advance (advance_s)
  );

  // Next-state, position counters and datapath controls.
  always_comb begin
    state_n_s    = state_r;
    bit_idx_n_s  = bit_idx_r;
    byte_cnt_n_s = byte_cnt_r;
    load_s       = 1'b0;
    drain_s      = 1'b0;
    underrun_n_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s || buf_full_r) begin
          state_n_s    = ASM;
          load_s       = 1'b1;
          bit_idx_n_s  = 5'd31;
          byte_cnt_n_s = {BCNT_W{1'b0}};
        end else begin
          state_n_s = IDLE;
        end
      end
      ASM: begin
        if (!advance_s) begin
          state_n_s = ASM;
        end else if (bit_idx_r == 5'd0) begin
          // Buffer was full on ASM entry and nothing drains during the marker.
          state_n_s    = DATA;
          drain_s      = 1'b1;
          bit_idx_n_s  = 5'd7;
          byte_cnt_n_s = {BCNT_W{1'b0}};
        end else begin
          bit_idx_n_s = bit_idx_r - 5'd1;
        end
      end
      DATA: begin
        if (!advance_s) begin
          state_n_s = DATA;
        end else if (bit_idx_r != 5'd0) begin
          bit_idx_n_s = bit_idx_r - 5'd1;
        end else if (byte_cnt_r == LAST_BYTE) begin
          if (buf_full_r) begin
            // Back-to-back frame: next byte stays buffered until marker ends.
            state_n_s    = ASM;
            load_s       = 1'b1;
            bit_idx_n_s  = 5'd31;
            byte_cnt_n_s = {BCNT_W{1'b0}};
          end else begin
            state_n_s = IDLE;
          end
        end else begin
          byte_cnt_n_s = byte_cnt_r + BCNT_W'(1'b1);
          bit_idx_n_s  = 5'd7;
          if (buf_full_r) begin
            drain_s = 1'b1;
          end else begin
            state_n_s    = STALL;
            underrun_n_s = 1'b1;
          end
        end
      end
      STALL: begin
        if (buf_full_r) begin
          state_n_s = DATA;
          drain_s   = 1'b1;
        end else begin
          state_n_s = STALL;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // FSM state, bit/byte positions and the underrun pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= IDLE;
      bit_idx_r  <= 5'd0;
      byte_cnt_r <= {BCNT_W{1'b0}};
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      bit_idx_r  <= bit_idx_n_s;
      byte_cnt_r <= byte_cnt_n_s;
      underrun_r <= underrun_n_s;
    end
  end

  // Holding buffer: a same-cycle drain and accept leaves it full with new data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_r      <= 8'h00;
      buf_full_r <= 1'b0;
      ready_r    <= 1'b0;
    end else if (accept_s) begin
      buf_r      <= data_i;
      buf_full_r <= 1'b1;
      ready_r    <= 1'b0;
    end else if (drain_s) begin
      buf_full_r <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      ready_r <= !buf_full_r;
    end
  end

  // Shift register takes the buffered byte at byte boundaries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shreg_r <= 8'h00;
    end else if (drain_s) begin
      shreg_r <= buf_r;
    end
  end

  // Serial bit selection from the marker word or the current byte.
  always_comb begin
    bit_s = 1'b0;
    if (state_r == ASM) begin
      bit_s = sel_bit(ASM_WORD, bit_idx_r);
    end else if (state_r == DATA) begin
      bit_s = shreg_r[bit_idx_r[2:0]];
    end else begin
      bit_s = 1'b0;
    end
  end

  assign ready_o       = ready_r;
  assign bit_o         = bit_s;
  assign bit_valid_o   = run_s;
  assign bit_strobe_o  = strobe_s;
  assign asm_o         = (state_r == ASM);
  assign frame_start_o = (state_r == ASM) && (bit_idx_r == 5'd31) && strobe_s;
  assign underrun_o    = underrun_r;

endmodule

// File: tb/tb_ccsds_asm_framer.sv
// Self-checking bench for ccsds_asm_framer with FRAME_BYTES=4. Output is
// captured every clock and reduced to a list of serial bits with their hold
// lengths, which is compared with a stream built from the sent bytes.
module tb_ccsds_asm_framer;

  localparam int unsigned FB   = 4;
  localparam logic [31:0] ASMW = 32'h1ACFFC1D;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] cycles_per_bit = 32'd0;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o, bit_o, bit_valid_o, bit_strobe_o, asm_o, frame_start_o, underrun_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ccsds_asm_framer #(.FRAME_BYTES(FB)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .cycles_per_bit (cycles_per_bit),
    .data_i         (data_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .bit_o          (bit_o),
    .bit_valid_o    (bit_valid_o),
    .bit_strobe_o   (bit_strobe_o),
    .asm_o          (asm_o),
    .frame_start_o  (frame_start_o),
    .underrun_o     (underrun_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Capture
  bit   mon_on = 1'b0;
  logic q_bit[$], q_vld[$], q_stb[$], q_asm[$], q_fs[$], q_ur[$];
  int   q_cyc[$];

  always @(negedge clk_i) begin
    if (mon_on) begin
      q_bit.push_back(bit_o);
      q_vld.push_back(bit_valid_o);
      q_stb.push_back(bit_strobe_o);
      q_asm.push_back(asm_o);
      q_fs.push_back(frame_start_o);
      q_ur.push_back(underrun_o);
      q_cyc.push_back(cyc);
    end
  end

  // Reduced view of a capture
  logic ex_bit[$];
  int   ex_len[$];
  int   ex_fs[$];
  int   n_vld, n_asm, n_ur, n_gap, n_stb, n_unstable;
  logic [7:0] tx_bytes[$];
  logic exp_bit[$];
  int   first_acc;

  task automatic extract();
    logic prev;
    bit   seen;
    int   k;
    ex_bit.delete(); ex_len.delete(); ex_fs.delete();
    n_vld = 0; n_asm = 0; n_ur = 0; n_gap = 0; n_stb = 0; n_unstable = 0;
    prev = 1'b0; seen = 1'b0;
    for (int i = 0; i < q_vld.size(); i++) begin
      if (q_fs[i] === 1'b1) ex_fs.push_back(q_cyc[i]);
      if (q_ur[i] === 1'b1) n_ur++;
      if (q_vld[i] === 1'b1) begin
        if (!prev && seen) n_gap++;
        seen = 1'b1;
        n_vld++;
        if (q_asm[i] === 1'b1) n_asm++;
        if (q_stb[i] === 1'b1) begin
          ex_bit.push_back(q_bit[i]);
          ex_len.push_back(1);
          n_stb++;
        end else if (ex_len.size() == 0) begin
          n_unstable++;
        end else begin
          k = ex_len.size() - 1;
          ex_len[k] = ex_len[k] + 1;
          if (q_bit[i] !== ex_bit[k]) n_unstable++;
        end
      end else if (q_stb[i] === 1'b1 || q_asm[i] === 1'b1 || q_bit[i] === 1'b1) begin
        n_unstable++;
      end
      prev = q_vld[i];
    end
  endtask

  // Expected serial stream: marker before every FB bytes, all MSB-first.
  task automatic build_expected();
    logic [31:0] w;
    logic [7:0]  b;
    exp_bit.delete();
    w = ASMW;
    for (int i = 0; i < tx_bytes.size(); i++) begin
      if (i % FB == 0) for (int k = 31; k >= 0; k--) exp_bit.push_back(w[k]);
      b = tx_bytes[i];
      for (int k = 7; k >= 0; k--) exp_bit.push_back(b[k]);
    end
  endtask

  task automatic feed_byte(input logic [7:0] b, output int acc, output bit ok);
    logic r;
    ok = 1'b0;
    acc = -1;
    data_i = b;
    valid_i = 1'b1;
    for (int w = 0; w < 400 && !ok; w++) begin
      r = ready_o;
      acc = cyc;
      @(posedge clk_i); #1;
      if (r === 1'b1) ok = 1'b1;
    end
    valid_i = 1'b0;
  endtask

  task automatic run_stream(input int cp, input int stall_idx, input int stall_len,
                            input int chg_at, input int cp2, input int tail);
    int acc;
    bit ok;
    cycles_per_bit = 32'(cp);
    q_bit.delete(); q_vld.delete(); q_stb.delete(); q_asm.delete();
    q_fs.delete(); q_ur.delete(); q_cyc.delete();
    first_acc = -1;
    mon_on = 1'b1;
    fork
      begin
        for (int i = 0; i < tx_bytes.size(); i++) begin
          if (i == stall_idx) begin
            for (int w = 0; w < 400 && ready_o !== 1'b1; w++) begin @(posedge clk_i); #1; end
            repeat (stall_len) begin @(posedge clk_i); #1; end
          end
          feed_byte(tx_bytes[i], acc, ok);
          if (i == 0) first_acc = acc;
          total++;
          if (!ok) begin
            bad++;
            $display("FAIL feed_timeout: byte %0d not accepted within 400 clocks", i);
          end
        end
      end
      begin
        if (chg_at > 0) begin
          repeat (chg_at) begin @(posedge clk_i); #1; end
          cycles_per_bit = 32'(cp2);
        end
      end
    join
    repeat (tail) begin @(posedge clk_i); #1; end
    mon_on = 1'b0;
    extract();
    build_expected();
  endtask

  task automatic rand_bytes(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({ready_o, bit_o, bit_valid_o, bit_strobe_o, asm_o, frame_start_o, underrun_o} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0000000",
        {ready_o, bit_o, bit_valid_o, bit_strobe_o, asm_o, frame_start_o, underrun_o});
    end
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready_held: got %b want 0", ready_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", ready_o); end
    total++;
    if (bit_valid_o !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", bit_valid_o); end
  endtask

  task automatic test_basic();
    tx_bytes.delete();
    tx_bytes.push_back(8'hA5); tx_bytes.push_back(8'h00);
    tx_bytes.push_back(8'hFF); tx_bytes.push_back(8'h3C);
    run_stream(0, -1, 0, 0, 0, 60);
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL basic_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      total++;
      if (ex_bit[i] !== exp_bit[i]) begin bad++; $display("FAIL basic_bit[%0d]: got %b want %b", i, ex_bit[i], exp_bit[i]); end
    end
    total++;
    if (n_vld !== 64) begin bad++; $display("FAIL basic_valid_cycles: got %0d want 64", n_vld); end
    total++;
    if (n_asm !== 32) begin bad++; $display("FAIL basic_asm_cycles: got %0d want 32", n_asm); end
    total++;
    if (ex_fs.size() !== 1) begin bad++; $display("FAIL basic_fs_count: got %0d want 1", ex_fs.size()); end
    if (ex_fs.size() > 0) begin
      total++;
      if (ex_fs[0] !== first_acc + 1) begin bad++; $display("FAIL basic_fs_latency: got cycle %0d want %0d", ex_fs[0], first_acc + 1); end
    end
    total++;
    if (n_gap !== 0 || n_ur !== 0 || n_unstable !== 0) begin
      bad++; $display("FAIL basic_clean: got gap=%0d ur=%0d unstable=%0d want 0 0 0", n_gap, n_ur, n_unstable);
    end
  endtask

  task automatic test_bit_period();
    rand_bytes(4);
    run_stream(3, -1, 0, 0, 0, 180);
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL period_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      total++;
      if (ex_bit[i] !== exp_bit[i] || ex_len[i] !== 4) begin
        bad++; $display("FAIL period_bit[%0d]: got %b/len %0d want %b/len 4", i, ex_bit[i], ex_len[i], exp_bit[i]);
      end
    end
    total++;
    if (n_vld !== 256 || n_stb !== 64) begin bad++; $display("FAIL period_totals: got vld=%0d stb=%0d want 256 64", n_vld, n_stb); end
    total++;
    if (n_unstable !== 0 || n_gap !== 0) begin bad++; $display("FAIL period_clean: got unstable=%0d gap=%0d want 0 0", n_unstable, n_gap); end
  endtask

  task automatic test_back_to_back(input int cp);
    rand_bytes(8);
    run_stream(cp, -1, 0, 0, 0, 40 * (cp + 1) + 20);
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL b2b_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      total++;
      if (ex_bit[i] !== exp_bit[i] || ex_len[i] !== cp + 1) begin
        bad++; $display("FAIL b2b_bit[%0d]: got %b/len %0d want %b/len %0d", i, ex_bit[i], ex_len[i], exp_bit[i], cp + 1);
      end
    end
    total++;
    if (n_vld !== 128 * (cp + 1) || n_gap !== 0) begin bad++; $display("FAIL b2b_continuous: got vld=%0d gap=%0d want %0d 0", n_vld, n_gap, 128 * (cp + 1)); end
    total++;
    if (ex_fs.size() !== 2) begin bad++; $display("FAIL b2b_fs_count: got %0d want 2", ex_fs.size()); end
    if (ex_fs.size() == 2) begin
      total++;
      if (ex_fs[1] - ex_fs[0] !== 64 * (cp + 1)) begin bad++; $display("FAIL b2b_fs_spacing: got %0d want %0d", ex_fs[1] - ex_fs[0], 64 * (cp + 1)); end
    end
    total++;
    if (n_asm !== 64 * (cp + 1)) begin bad++; $display("FAIL b2b_asm_cycles: got %0d want %0d", n_asm, 64 * (cp + 1)); end
  endtask

  task automatic test_underrun();
    rand_bytes(4);
    run_stream(1, 2, 20, 0, 0, 100);
    total++;
    if (n_ur !== 1) begin bad++; $display("FAIL underrun_pulses: got %0d want 1", n_ur); end
    total++;
    if (n_gap !== 1) begin bad++; $display("FAIL underrun_stall_gap: got %0d want 1", n_gap); end
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL underrun_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      total++;
      if (ex_bit[i] !== exp_bit[i] || ex_len[i] !== 2) begin
        bad++; $display("FAIL underrun_bit[%0d]: got %b/len %0d want %b/len 2", i, ex_bit[i], ex_len[i], exp_bit[i]);
      end
    end
    total++;
    if (n_vld !== 128 || n_unstable !== 0) begin bad++; $display("FAIL underrun_totals: got vld=%0d unstable=%0d want 128 0", n_vld, n_unstable); end
  endtask

  task automatic test_reset_mid_asm();
    int  acc;
    bit  ok;
    logic [31:0] w;
    w = ASMW;
    cycles_per_bit = 32'd0;
    feed_byte(8'($urandom_range(0, 255)), acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL rstasm_feed: byte not accepted within 400 clocks"); end
    for (int k = 0; k < 100 && cyc != acc + 22; k++) begin @(posedge clk_i); #1; end
    total++;
    if (asm_o !== 1'b1 || bit_o !== w[10]) begin bad++; $display("FAIL rstasm_bit10: got asm=%b bit=%b want 1 %b", asm_o, bit_o, w[10]); end
    #2 rst_ni = 1'b0;
    #1;
    total++;
    if ({ready_o, bit_o, bit_valid_o, bit_strobe_o, asm_o, frame_start_o, underrun_o} !== 7'b0) begin
      bad++; $display("FAIL rstasm_async_outputs: got %b want 0000000",
        {ready_o, bit_o, bit_valid_o, bit_strobe_o, asm_o, frame_start_o, underrun_o});
    end
    @(posedge clk_i); #1;
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL rstasm_ready_in_reset: got %b want 0", ready_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    rand_bytes(4);
    run_stream(0, -1, 0, 0, 0, 60);
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL rstasm_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      total++;
      if (ex_bit[i] !== exp_bit[i]) begin bad++; $display("FAIL rstasm_bit[%0d]: got %b want %b", i, ex_bit[i], exp_bit[i]); end
    end
    total++;
    if (ex_fs.size() !== 1 || n_vld !== 64) begin bad++; $display("FAIL rstasm_frame: got fs=%0d vld=%0d want 1 64", ex_fs.size(), n_vld); end
  endtask

  task automatic test_period_change();
    int want;
    rand_bytes(8);
    run_stream(0, -1, 0, 45, 2, 140);
    total++;
    if (ex_bit.size() !== exp_bit.size()) begin bad++; $display("FAIL pchg_nbits: got %0d want %0d", ex_bit.size(), exp_bit.size()); end
    for (int i = 0; i < exp_bit.size() && i < ex_bit.size(); i++) begin
      want = (i < 64) ? 1 : 3;
      total++;
      if (ex_bit[i] !== exp_bit[i] || ex_len[i] !== want) begin
        bad++; $display("FAIL pchg_bit[%0d]: got %b/len %0d want %b/len %0d", i, ex_bit[i], ex_len[i], exp_bit[i], want);
      end
    end
    total++;
    if (n_vld !== 256 || n_gap !== 0) begin bad++; $display("FAIL pchg_totals: got vld=%0d gap=%0d want 256 0", n_vld, n_gap); end
    total++;
    if (ex_fs.size() !== 2) begin bad++; $display("FAIL pchg_fs_count: got %0d want 2", ex_fs.size()); end
    if (ex_fs.size() == 2) begin
      total++;
      if (ex_fs[1] - ex_fs[0] !== 64) begin bad++; $display("FAIL pchg_fs_spacing: got %0d want 64", ex_fs[1] - ex_fs[0]); end
    end
    cycles_per_bit = 32'd0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bit_period();
    test_back_to_back(0);
    test_underrun();
    test_reset_mid_asm();
    test_period_change();
    test_back_to_back($urandom_range(1, 4));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
